count_bin_sys_pll_reset_seq: RTL and testbench
==============================================

# count_bin_sys_pll_reset_seq

Reset sequencer that sits directly upstream of the system/SDRAM PLL. It drives the PLL's `rst` input, watches its `locked` output, and releases the SDRAM-side and system resets in a fixed order only after lock has been stable. If lock is lost or never arrives, it re-resets the PLL and retries. It runs on the 50 MHz board reference clock, which keeps running while the PLL is held in reset.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse, in clocks.
- `LOCK_TIMEOUT`, 20000: clocks spent waiting for lock before the PLL is re-reset.
- `STABLE_CYCLES`, 1024: consecutive clocks of synchronised lock required before any release.
- `STAGE_GAP`, 256: clocks between `sdram_rst` release and `sys_rst` release.

Ports:
- `clk`  in  1: board reference clock; the same net that feeds the PLL `refclk`.
- `rst`  in  1: synchronous, active-high reset.
- `pll_locked`  in  1: PLL `locked` output; asynchronous to `clk`.
- `pll_rst`  out  1: drives the PLL `rst` input; active high.
- `sdram_rst`  out  1: reset for SDRAM controller logic; active high.
- `sys_rst`  out  1: reset for the remaining system logic; active high.
- `ready`  out  1: high when the sequence is complete and lock is held.
- `fault_cnt`  out  8: count of lock timeouts plus lock losses in RUN; saturates.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to produce `locked_s`. Both flops reset to 0.
- One counter, `cnt`, is shared by all states. Its width is `$clog2` of the largest parameter. It clears on every state change.
- All outputs are registered and decoded from the state register. There are no combinational paths from inputs to outputs.
- States and transitions:
  - PLL_RST: `pll_rst`=1. Go to WAIT_LOCK when `cnt`==`PLL_RST_CYCLES`-1.
  - WAIT_LOCK: `pll_rst`=0. If `locked_s`=1, go to STABLE. Otherwise, when `cnt`==`LOCK_TIMEOUT`-1, go to PLL_RST and increment `fault_cnt`.
  - STABLE: if `locked_s`=0, go to WAIT_LOCK; `cnt` restarts and `fault_cnt` does not increment. Go to REL_SDRAM when `cnt`==`STABLE_CYCLES`-1 with `locked_s` still 1.
  - REL_SDRAM: `sdram_rst`=0. If `locked_s`=0, go to PLL_RST and increment `fault_cnt`. Go to RUN when `cnt`==`STAGE_GAP`-1.
  - RUN: `sdram_rst`=0, `sys_rst`=0, `ready`=1. If `locked_s`=0, go to PLL_RST and increment `fault_cnt`.
- Output values by state:
  - `sdram_rst`=1 in PLL_RST, WAIT_LOCK and STABLE.
  - `sys_rst`=1 in every state except RUN.
  - `ready`=1 only in RUN.
- `fault_cnt` saturates at 255. It is cleared only by `rst`.
- Release order is always `sdram_rst` first, then `sys_rst`. On any fault, `sdram_rst` and `sys_rst` assert together.
- Reset deassertion crosses into the PLL output domains. Each consumer re-synchronises deassertion locally; that logic is outside this block.

## Timing
- While `rst`=1, on every edge:
  - state goes to PLL_RST and `cnt` to 0.
  - `pll_rst`=1, `sdram_rst`=1, `sys_rst`=1.
  - `ready`=0 and `fault_cnt`=0.
  - The synchroniser flops go to 0.
- `rst` asserted mid-sequence, including in RUN: on the next edge all outputs return to their reset values and the sequence restarts.
- Edge numbering: edge 1 is the first edge with `rst`=0.
  - `pll_rst` deasserts after edge `PLL_RST_CYCLES`.
- Lock detection latency is 2 clocks (synchroniser) plus 1 clock (state register) from `pll_locked` rising to STABLE.
- Lock loss in RUN: `sys_rst`/`sdram_rst` assert and `ready` falls 3 edges after `pll_locked` falls. `pll_rst` rises on the same edge.
- Glitch handling: a `pll_locked` low pulse shorter than 1 clock may be missed, which is acceptable. Any pulse seen by `locked_s` in STABLE restarts the stability window.
- `LOCK_TIMEOUT`, `STABLE_CYCLES` and `STAGE_GAP` must each be at least 1. `PLL_RST_CYCLES` must be at least 2.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `STAGE_GAP`=4.

- Clean lock: hold `pll_locked`=1 throughout.
  - `pll_rst` falls after edge 4 and STABLE is entered at edge 5.
  - `sdram_rst` falls after edge 13.
  - `sys_rst` falls and `ready` rises after edge 17.
  - `fault_cnt`=0.
- No lock: hold `pll_locked`=0.
  - `pll_rst` is low for edges 5–36 and high again for edges 37–40.
  - `fault_cnt` increments at each timeout: 1, then 2.
- Stability glitch: `pll_locked` drops for 3 clocks midway through STABLE.
  - Flow returns to WAIT_LOCK and the 8-cycle window restarts.
  - `sdram_rst` release is delayed accordingly; `fault_cnt` stays 0.
- Lock loss in RUN: from RUN, drop `pll_locked`.
  - Within 3 edges: `sys_rst`=`sdram_rst`=`pll_rst`=1, `ready`=0, `fault_cnt`=1.
  - With `pll_locked` restored, the full sequence repeats.
- Saturation and reset: force 300 timeouts.
  - `fault_cnt` holds at 255.
  - Assert `rst` for 1 clock in RUN: all outputs take their reset values on the next edge and `fault_cnt`=0.

Source files
------------

// File: rtl/count_bin_sys_pll_reset_seq.sv
// Reset sequencer for the system/SDRAM PLL: pulses the PLL reset, waits for stable lock,
// then releases SDRAM reset followed by system reset; re-resets the PLL on timeout or lock loss.
module count_bin_sys_pll_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 20000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] fault_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_REL_SDRAM,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, locked_s_q;
  logic             fault_inc;
  logic             pll_rst_q, sdram_rst_q, sys_rst_q, ready_q;
  logic [7:0]       fault_cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    fault_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          state_d   = S_PLL_RST;
          fault_inc = 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout here is not a fault; it only restarts the stability window.
        if (!locked_s_q) state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_REL_SDRAM;
      end
      S_REL_SDRAM: begin
        if (!locked_s_q) begin
          state_d   = S_PLL_RST;
          fault_inc = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d   = S_PLL_RST;
          fault_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sdram_rst_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_cnt_q <= 8'd0;
    end else begin
      sync1_q     <= pll_locked;
      locked_s_q  <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == S_PLL_RST);
      sdram_rst_q <= (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
      sys_rst_q   <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      if (fault_inc) fault_cnt_q <= sat_inc(fault_cnt_q);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sdram_rst = sdram_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_count_bin_sys_pll_reset_seq.sv
// Directed bench for count_bin_sys_pll_reset_seq with short timing parameters.
module tb_count_bin_sys_pll_reset_seq;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sdram_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] fault_cnt;

  int n_cmp  = 0;
  int n_bad  = 0;
  int edge_n = 0;

  count_bin_sys_pll_reset_seq #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .STAGE_GAP     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sdram_rst (sdram_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int e_pll, input int e_sdram,
                          input int e_sys, input int e_rdy, input int e_fault);
    chk($sformatf("%s.pll_rst", tag),   32'(pll_rst),   32'(e_pll));
    chk($sformatf("%s.sdram_rst", tag), 32'(sdram_rst), 32'(e_sdram));
    chk($sformatf("%s.sys_rst", tag),   32'(sys_rst),   32'(e_sys));
    chk($sformatf("%s.ready", tag),     32'(ready),     32'(e_rdy));
    chk($sformatf("%s.fault_cnt", tag), 32'(fault_cnt), 32'(e_fault));
  endtask

  // Advance one edge; the bench then sits 1 time unit after it, so edge_n names the last edge seen.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (3) step();
    chk_outs(tag, 1, 1, 1, 0, 0);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Clean lock, then lock loss in RUN and recovery
    pll_locked = 1'b1;
    do_reset("rst_a");
    run_to(3);  chk_outs("cl3",  1, 1, 1, 0, 0);
    run_to(4);  chk_outs("cl4",  0, 1, 1, 0, 0);
    run_to(12); chk_outs("cl12", 0, 1, 1, 0, 0);
    run_to(13); chk_outs("cl13", 0, 0, 1, 0, 0);
    run_to(16); chk_outs("cl16", 0, 0, 1, 0, 0);
    run_to(17); chk_outs("cl17", 0, 0, 0, 1, 0);
    run_to(20); pll_locked = 1'b0;
    run_to(22); chk_outs("ll22", 0, 0, 0, 1, 0);
    run_to(23); chk_outs("ll23", 1, 1, 1, 0, 1);
    pll_locked = 1'b1;
    run_to(26); chk_outs("ll26", 1, 1, 1, 0, 1);
    run_to(27); chk_outs("ll27", 0, 1, 1, 0, 1);
    run_to(35); chk_outs("ll35", 0, 1, 1, 0, 1);
    run_to(36); chk_outs("ll36", 0, 0, 1, 0, 1);
    run_to(39); chk_outs("ll39", 0, 0, 1, 0, 1);
    run_to(40); chk_outs("ll40", 0, 0, 0, 1, 1);

    // No lock: periodic timeouts
    pll_locked = 1'b0;
    do_reset("rst_b");
    run_to(4);  chk_outs("nl4",  0, 1, 1, 0, 0);
    run_to(35); chk_outs("nl35", 0, 1, 1, 0, 0);
    run_to(36); chk_outs("nl36", 1, 1, 1, 0, 1);
    run_to(39); chk_outs("nl39", 1, 1, 1, 0, 1);
    run_to(40); chk_outs("nl40", 0, 1, 1, 0, 1);
    run_to(71); chk_outs("nl71", 0, 1, 1, 0, 1);
    run_to(72); chk_outs("nl72", 1, 1, 1, 0, 2);

    // Three-clock dropout inside STABLE restarts the window
    pll_locked = 1'b1;
    do_reset("rst_c");
    run_to(8);  pll_locked = 1'b0;
    run_to(11); pll_locked = 1'b1;
    run_to(12); chk_outs("gl12", 0, 1, 1, 0, 0);
    run_to(13); chk_outs("gl13", 0, 1, 1, 0, 0);
    run_to(21); chk_outs("gl21", 0, 1, 1, 0, 0);
    run_to(22); chk_outs("gl22", 0, 0, 1, 0, 0);
    run_to(25); chk_outs("gl25", 0, 0, 1, 0, 0);
    run_to(26); chk_outs("gl26", 0, 0, 0, 1, 0);

    // 300 timeouts: counter saturates, then reset from RUN clears it
    pll_locked = 1'b0;
    do_reset("rst_d");
    run_to(9179);  chk("sat9179", 32'(fault_cnt), 32'd254);
    run_to(9180);  chk("sat9180", 32'(fault_cnt), 32'd255);
    run_to(9216);  chk("sat9216", 32'(fault_cnt), 32'd255);
    run_to(10800); chk("sat10800", 32'(fault_cnt), 32'd255);
    pll_locked = 1'b1;
    for (int i = 0; i < 200 && !ready; i++) step();
    chk_outs("satrun", 0, 0, 0, 1, 255);
    rst = 1'b1;
    step();
    chk_outs("rstrun", 1, 1, 1, 0, 0);
    rst = 1'b0;
    step();
    chk_outs("rstrel", 1, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
